// File: rtl/midi_out_tx_if.sv
// midi_out_tx_if: valid/ready event handshake between a MIDI event source and midi_out_tx.
interface midi_out_tx_if;
    logic       inEventValid;
    logic       outEventReady;
    logic [1:0] inEventType;
    logic [3:0] inChannel;
    logic [6:0] inData1;
    logic [6:0] inData2;
    modport master (output inEventValid, inEventType, inChannel, inData1, inData2, input outEventReady);
    modport slave  (input inEventValid, inEventType, inChannel, inData1, inData2, output outEventReady);
endinterface

// File: rtl/midi_out_tx.sv
// midi_out_tx: encodes MIDI channel-voice events and shifts them out as 31250-baud 8N1 serial.
// Next-byte selection is done on the edge that leaves IDLE or STOP, so it costs no line time.
module midi_out_tx #(
    parameter int CLKS_PER_BIT   = 1600,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic         IN_CLOCK,
    input  logic         IN_RESET,
    midi_out_tx_if.slave ev,
    output logic         outMidiOut,
    output logic         outBusy,
    output logic         outByteSent
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitn, bitn_n;
    logic [7:0]    sh, sh_n, last_st, last_st_n, st;
    logic [1:0]    idx, idx_n, last_idx, last_idx_n;
    logic [6:0]    d1, d1_n, d2, d2_n;
    logic          tx_n, tick, need_st;
    assign tick    = cnt == CW'(CLKS_PER_BIT - 1);
    assign st      = {ev.inEventType == 2'd0 ? 4'h8 :
                      ev.inEventType == 2'd1 ? 4'h9 :
                      ev.inEventType == 2'd2 ? 4'hB : 4'hC, ev.inChannel};
    assign need_st = !RUNNING_STATUS || st != last_st;
    assign ev.outEventReady = state == IDLE;
    assign outBusy          = state != IDLE;
    assign outByteSent      = state == STOP && tick;
    always_comb begin
        state_n    = state;
        cnt_n      = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        bitn_n     = bitn;
        sh_n       = sh;
        idx_n      = idx;
        last_idx_n = last_idx;
        d1_n       = d1;
        d2_n       = d2;
        last_st_n  = last_st;
        unique case (state)
            IDLE: if (ev.inEventValid) begin
                state_n    = START;
                d1_n       = ev.inData1;
                d2_n       = ev.inData2;
                idx_n      = need_st ? 2'd0 : 2'd1;
                last_idx_n = ev.inEventType == 2'd3 ? 2'd1 : 2'd2;
                sh_n       = need_st ? st : {1'b0, ev.inData1};
                if (RUNNING_STATUS && need_st) last_st_n = st;
            end
            START: if (tick) begin
                state_n = DATA;
                bitn_n  = '0;
            end
            DATA: if (tick) begin
                sh_n   = sh >> 1;
                bitn_n = bitn + 1'b1;
                if (bitn == 3'd7) state_n = STOP;
            end
            STOP: if (tick) begin
                state_n = idx == last_idx ? IDLE : START;
                idx_n   = idx + 1'b1;
                sh_n    = {1'b0, idx == 2'd0 ? d1 : d2};
            end
            default: state_n = IDLE;
        endcase
        // line is registered from next state so reset drives it high without a low glitch
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
    end
    always_ff @(posedge IN_CLOCK or posedge IN_RESET) begin
        if (IN_RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            bitn       <= '0;
            sh         <= '0;
            idx        <= '0;
            last_idx   <= '0;
            d1         <= '0;
            d2         <= '0;
            last_st    <= 8'h00;
            outMidiOut <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bitn       <= bitn_n;
            sh         <= sh_n;
            idx        <= idx_n;
            last_idx   <= last_idx_n;
            d1         <= d1_n;
            d2         <= d2_n;
            last_st    <= last_st_n;
            outMidiOut <= tx_n;
        end
    end
endmodule
